// File: rtl/mem_stage_lsu.sv
// Load/store memory stage: sized accesses, byte enables, req/ack bus,
// valid/ready flow control, misalignment detection and a bus watchdog.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   in_valid/in_ready     upstream handshake; in_addr, in_store_data,
//                         in_mem_read, in_mem_write, in_size, in_unsigned,
//                         in_ctrl describe the op
//   out_valid/out_ready   downstream handshake; out_alu_data,
//                         out_load_data, out_ctrl, out_misaligned,
//                         out_bus_error form the result beat
//   mem_req/mem_ack       memory handshake; mem_we, mem_addr, mem_wdata,
//                         mem_be are request fields, mem_rdata the reply
module mem_stage_lsu #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int CTRL_W   = 16,
    parameter int MAX_WAIT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_store_data,
    input  logic                in_mem_read,
    input  logic                in_mem_write,
    input  logic [1:0]          in_size,
    input  logic                in_unsigned,
    input  logic [CTRL_W-1:0]   in_ctrl,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_alu_data,
    output logic [DATA_W-1:0]   out_load_data,
    output logic [CTRL_W-1:0]   out_ctrl,
    output logic                out_misaligned,
    output logic                out_bus_error,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = $clog2(MAX_WAIT + 2);

    typedef enum logic {IDLE, MEM} state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [OFF_W-1:0]   off_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic               load_q;

    logic               accept;
    logic               is_mem;
    logic               misaligned;
    logic               expired;
    logic [OFF_W-1:0]   off;
    logic [NB-1:0]      be_next;
    logic [DATA_W-1:0]  wdata_next;
    logic [DATA_W-1:0]  shifted;
    logic [DATA_W-1:0]  load_ext;
    logic               sign;
    int                 lanes;
    int                 nbits;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mem   = in_mem_read || in_mem_write;
    assign off      = in_addr[OFF_W-1:0];
    // Fires on the MAX_WAIT-th MEM cycle; a same-cycle ack takes priority.
    assign expired  = (MAX_WAIT != 0) &&
                      (32'(wait_cnt) == 32'(MAX_WAIT - 1));

    always_comb begin
        unique case (in_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = in_addr[0];
            2'd2:    misaligned = (in_addr[1:0] != 2'b00);
            default: misaligned = (DATA_W == 32) || (in_addr[2:0] != 3'b000);
        endcase
    end

    // Store data replicated per access size; enables cover the sized
    // window starting at the byte offset.
    always_comb begin
        lanes = 1 << in_size;
        if (lanes > NB) lanes = NB;
        be_next    = '0;
        wdata_next = '0;
        for (int i = 0; i < NB; i++) begin
            wdata_next[8*i +: 8] = in_store_data[8*(i % lanes) +: 8];
            if (i >= int'(off) && i < int'(off) + lanes)
                be_next[i] = 1'b1;
        end
    end

    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        nbits   = 8 << size_q;
        if (nbits > DATA_W) nbits = DATA_W;
        sign = 1'b0;
        for (int i = 0; i < DATA_W; i++)
            if (i == nbits - 1) sign = shifted[i] && !uns_q;
        load_ext = '0;
        for (int i = 0; i < DATA_W; i++)
            load_ext[i] = (i < nbits) ? shifted[i] : sign;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            off_q          <= '0;
            size_q         <= '0;
            uns_q          <= 1'b0;
            load_q         <= 1'b0;
            out_valid      <= 1'b0;
            out_alu_data   <= '0;
            out_load_data  <= '0;
            out_ctrl       <= '0;
            out_misaligned <= 1'b0;
            out_bus_error  <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_be         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        out_alu_data   <= DATA_W'(in_addr);
                        out_ctrl       <= in_ctrl;
                        out_load_data  <= '0;
                        out_bus_error  <= 1'b0;
                        out_misaligned <= 1'b0;
                        if (is_mem && !misaligned) begin
                            state     <= MEM;
                            out_valid <= 1'b0;
                            mem_req   <= 1'b1;
                            mem_we    <= in_mem_write;
                            mem_addr  <= {in_addr[ADDR_W-1:OFF_W],
                                          {OFF_W{1'b0}}};
                            mem_wdata <= wdata_next;
                            mem_be    <= in_mem_write ? be_next : '0;
                            off_q     <= off;
                            size_q    <= in_size;
                            uns_q     <= in_unsigned;
                            load_q    <= !in_mem_write;
                            wait_cnt  <= '0;
                        end else begin
                            // ALU op, or a suppressed misaligned access
                            out_valid      <= 1'b1;
                            out_misaligned <= is_mem;
                        end
                    end else if (out_ready) begin
                        out_valid      <= 1'b0;
                        out_misaligned <= 1'b0;
                        out_bus_error  <= 1'b0;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        state         <= IDLE;
                        mem_req       <= 1'b0;
                        mem_we        <= 1'b0;
                        out_valid     <= 1'b1;
                        out_load_data <= load_q ? load_ext : '0;
                    end else if (expired) begin
                        state         <= IDLE;
                        mem_req       <= 1'b0;
                        mem_we        <= 1'b0;
                        out_valid     <= 1'b1;
                        out_bus_error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
